serial_alu_word: RTL

- Parametrised successor to the team's single-bit serial ALU.
- Processes WIDTH-bit operands streamed LSB-first, one bit per accepted cycle, framed by a start/done handshake.
- Adds subtraction, shift-left and word-level flags (zero, carry, overflow).
- Sits between the scan-wrapper IO pins and user logic: op on upper pins, a/b bits on lower pins.

---
 rtl/serial_alu_pkg.sv | 48 ++++
 rtl/serial_alu_bitslice.sv | 49 ++++
 rtl/serial_alu_word.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared op codes, FSM states and per-op helpers for the word-level serial ALU.
// SERIAL_ALU_WORD_CMP_EN enables the cmp op (0011); otherwise 0011 is an unknown op.
package serial_alu_pkg;

  localparam logic [3:0] NEG = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] CMP = 4'b0011;
  localparam logic [3:0] SHL = 4'b0100;
  localparam logic [3:0] NOT = 4'b1000;
  localparam logic [3:0] OR  = 4'b1001;
  localparam logic [3:0] AND = 4'b1010;
  localparam logic [3:0] XOR = 4'b1100;

  typedef enum logic {IDLE, RUN} state_e;

  // Subtract-style ops start with carry=1 so ~b + 1 forms the two's complement.
  function automatic logic carry_init(input logic [3:0] op);
    case (op)
      SUB, NEG: carry_init = 1'b1;
`ifdef SERIAL_ALU_WORD_CMP_EN
      CMP:      carry_init = 1'b1;
`endif
      default:  carry_init = 1'b0;
    endcase
  endfunction

  function automatic logic has_carry(input logic [3:0] op);
    case (op)
      ADD, SUB, NEG, SHL: has_carry = 1'b1;
`ifdef SERIAL_ALU_WORD_CMP_EN
      CMP:                has_carry = 1'b1;
`endif
      default:            has_carry = 1'b0;
    endcase
  endfunction

  function automatic logic has_ovf(input logic [3:0] op);
    case (op)
      ADD, SUB: has_ovf = 1'b1;
`ifdef SERIAL_ALU_WORD_CMP_EN
      CMP:      has_ovf = 1'b1;
`endif
      default:  has_ovf = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_alu_bitslice.sv
// One-bit combinational ALU slice; carry is threaded through the top's carry register.
// SERIAL_ALU_WORD_CMP_EN maps cmp onto the subtract path.
module serial_alu_bitslice
  import serial_alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  output logic       r,
  output logic       c_out
);

  always_comb begin
    r     = 1'b0;
    c_out = 1'b0;
    case (op)
      ADD: begin
        r     = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
      end
`ifdef SERIAL_ALU_WORD_CMP_EN
      SUB, CMP: begin
`else
      SUB: begin
`endif
        r     = a ^ ~b ^ c_in;
        c_out = (a & ~b) | (a & c_in) | (~b & c_in);
      end
      NEG: begin
        r     = ~a ^ c_in;
        c_out = ~a & c_in;
      end
      SHL: begin
        r     = c_in;
        c_out = a;
      end
      OR:  r = a | b;
      AND: r = a & b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      default: begin
        r     = 1'b0;
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_word.sv
// WIDTH-bit LSB-first serial ALU with start/done framing and word-level flags.
// Optional cmp op enabled by defining SERIAL_ALU_WORD_CMP_EN.
module serial_alu_word
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  output logic       out,
  output logic       out_valid,
  output logic       done,
  output logic       flag_zero,
  output logic       flag_carry,
  output logic       flag_ovf
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic          c_q;
  logic          zacc;
  logic          r, c_out;
  logic          consume, last_bit, accept;

  assign accept   = (state == IDLE) && start;
  assign consume  = (state == RUN) && in_valid;
  assign last_bit = consume && (cnt == LAST);

  serial_alu_bitslice u_slice (
    .op    (op_q),
    .a     (a),
    .b     (b),
    .c_in  (c_q),
    .r     (r),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      cnt        <= '0;
      op_q       <= 4'b0;
      c_q        <= 1'b0;
      zacc       <= 1'b0;
    end else begin
      out_valid <= consume;
      done      <= last_bit;
      if (accept) begin
        op_q <= op;
        c_q  <= carry_init(op);
        cnt  <= '0;
        zacc <= 1'b0;
      end
      if (consume) begin
        out  <= r;
        c_q  <= c_out;
        cnt  <= cnt + 1'b1;
        zacc <= zacc | r;
      end
      // c_q is the carry into the MSB here, c_out the carry out of it.
      if (last_bit) begin
        flag_zero  <= ~(zacc | r);
        flag_carry <= has_carry(op_q) ? c_out : 1'b0;
        flag_ovf   <= has_ovf(op_q) ? (c_q ^ c_out) : 1'b0;
      end
    end
  end

endmodule
